// File: rtl/ctc_pkg.sv
// Bus timing and instruction constants shared by the CTC and the serial ROM chips.
// Bit times count T0..T55 within one 56-bit word.
package ctc_pkg;

    typedef logic [9:0] word10_t;

    localparam logic [5:0] T_IA_FIRST = 6'd20;
    localparam logic [5:0] T_IA_LAST  = 6'd27;
    localparam logic [5:0] T_READ     = 6'd28;
    localparam logic [5:0] T_LOAD     = 6'd44;
    localparam logic [5:0] T_IS_FIRST = 6'd45;
    localparam logic [5:0] T_IS_LAST  = 6'd54;
    localparam logic [5:0] T_LAST     = 6'd55;

    localparam logic [6:0] OP_ROMSEL  = 7'b0010000;
    localparam int         ROMSEL_MSB = 9;
    localparam int         ROMSEL_LSB = 7;

    function automatic logic in_is_window(input logic [5:0] t);
        return (t >= T_IS_FIRST) && (t <= T_IS_LAST);
    endfunction

endpackage

// File: rtl/rom_array.sv
// 256 x 10 instruction memory with a registered read port.
// Contents start as all zero; reset clears only the read register.
module rom_array
  import ctc_pkg::*;
#(
  parameter INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_en,
  input  logic [7:0] addr,
  output word10_t    data
);

  word10_t mem [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (rd_en) begin
      data <= mem[addr];
    end
  end

endmodule

// File: rtl/serial_rom.sv
// Serial instruction ROM on the CTC IA/IS/SYNC bus: aligns to SYNC, takes an address on IA,
// returns the addressed word on IS, and snoops IS for ROM-select instructions.
module serial_rom
    import ctc_pkg::*;
#(
    parameter logic [2:0] ROM_ID    = 3'd0,
    parameter             INIT_FILE = ""
) (
    input  logic cph2,
    input  logic pon,
    input  logic ia,
    input  logic sync,
    input  logic is_in,
    output logic is_out,
    output logic is_oe,
    output logic locked,
    output logic active
);

    logic [5:0] bit_cnt;
    logic [5:0] cnt_inc;
    logic       sync_d;
    logic       checking;
    logic       in_window;
    logic       sync_rise;
    logic       sync_bad;
    logic [2:0] selected;
    logic [7:0] addr_sr;
    logic [7:0] addr_r;
    word10_t    data_r;
    word10_t    out_sr;
    word10_t    snoop_sr;

    assign in_window = in_is_window(bit_cnt);
    assign sync_rise = sync & ~sync_d;
    // SYNC must be high exactly across the IS window; anything else breaks alignment.
    assign sync_bad  = (sync != in_window);
    assign cnt_inc   = (bit_cnt == T_LAST) ? 6'd0 : bit_cnt + 6'd1;

    always_ff @(posedge cph2 or posedge pon) begin
        if (pon) begin
            bit_cnt  <= '0;
            sync_d   <= 1'b0;
            locked   <= 1'b0;
            checking <= 1'b0;
        end else begin
            sync_d <= sync;
            if (sync_rise && (!locked || sync_bad)) begin
                bit_cnt  <= T_IS_FIRST + 6'd1;
                checking <= 1'b1;
                locked   <= 1'b0;
            end else begin
                bit_cnt <= cnt_inc;
                if (locked) begin
                    if (sync_bad) begin
                        locked <= 1'b0;
                    end
                end else if (checking) begin
                    if (sync_bad) begin
                        checking <= 1'b0;
                    end else if (bit_cnt == T_LAST) begin
                        locked   <= 1'b1;
                        checking <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge cph2 or posedge pon) begin
        if (pon) begin
            addr_sr  <= '0;
            addr_r   <= '0;
            out_sr   <= '0;
            snoop_sr <= '0;
            selected <= '0;
        end else begin
            if ((bit_cnt >= T_IA_FIRST) && (bit_cnt <= T_IA_LAST)) begin
                addr_sr <= {ia, addr_sr[7:1]};
            end
            if (bit_cnt == T_IA_LAST) begin
                addr_r <= {ia, addr_sr[7:1]};
            end
            if (bit_cnt == T_LOAD) begin
                out_sr <= data_r;
            end else if (in_window) begin
                out_sr <= {1'b0, out_sr[9:1]};
            end
            if (in_window) begin
                snoop_sr <= {is_in, snoop_sr[9:1]};
            end
            // A word whose SYNC framing failed never changes the selection.
            if ((bit_cnt == T_LAST) && locked && !sync_bad &&
                (snoop_sr[ROMSEL_LSB-1:0] == OP_ROMSEL)) begin
                selected <= snoop_sr[ROMSEL_MSB:ROMSEL_LSB];
            end
        end
    end

    rom_array #(
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk  (cph2),
        .rst  (pon),
        .rd_en(bit_cnt == T_READ),
        .addr (addr_r),
        .data (data_r)
    );

    assign active = (selected == ROM_ID);
    assign is_oe  = locked & active & in_window;
    assign is_out = is_oe & out_sr[0];

endmodule
